// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: sequencer state encoding and default timing constants
package pll_ctrl_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_e;
  localparam int DEF_RST_PULSE_CYC = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC = 256;
  localparam int DEF_MAX_RETRY = 3;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input logic clk,
  input logic rst,
  input logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk)
    if (rst) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for stable lock, then releases the datapath reset
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input logic refclk,
  input logic rst,
  input logic pll_locked,
  output logic pll_rst,
  output logic sys_rst,
  output logic ready,
  output logic fault,
  output logic [7:0] lock_loss_cnt
);
  localparam int MAXC = RST_PULSE_CYC > LOCK_TIMEOUT_CYC ?
    (RST_PULSE_CYC > LOCK_STABLE_CYC ? RST_PULSE_CYC : LOCK_STABLE_CYC) :
    (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic locked_s, pulse_done, timeout, stable_done;
  sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(locked_s));
  assign pulse_done = cnt == CW'(RST_PULSE_CYC - 1);
  assign timeout = cnt == CW'(LOCK_TIMEOUT_CYC - 1);
  assign stable_done = cnt == CW'(LOCK_STABLE_CYC - 1);
  assign retry_nxt = retry_cnt + RW'(1);
  always_comb begin
    nxt = state;
    case (state)
      RESET_PLL: nxt = pulse_done ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: nxt = locked_s ? STABILIZE : !timeout ? WAIT_LOCK :
                       retry_nxt == RW'(MAX_RETRY) ? FAULT : RESET_PLL;
      STABILIZE: nxt = !locked_s ? WAIT_LOCK : stable_done ? RUN : STABILIZE;
      RUN:       nxt = locked_s ? RUN : RESET_PLL;
      default:   nxt = FAULT;
    endcase
  end
  always_ff @(posedge refclk)
    if (rst) begin
      state <= RESET_PLL;
      cnt <= '0;
      retry_cnt <= '0;
      lock_loss_cnt <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + CW'(1);
      if (state == WAIT_LOCK && !locked_s && timeout) retry_cnt <= retry_nxt;
      else if (nxt == RUN && state != RUN) retry_cnt <= '0;
      if (state == RUN && !locked_s && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      pll_rst <= nxt == RESET_PLL || nxt == FAULT;
      sys_rst <= nxt != RUN;
      ready <= nxt == RUN;
      fault <= nxt == FAULT;
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of startup, lock loss, stabilize glitch, timeouts, saturation and reset
module tb_pll_reset_sequencer;
  logic refclk = 1'b0, rst, pll_locked;
  logic pll_rst, sys_rst, ready, fault;
  logic [7:0] lock_loss_cnt;
  int total = 0, passed = 0, fails = 0, n;
  pll_reset_sequencer #(
    .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8), .MAX_RETRY(3)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .fault(fault), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 refclk = ~refclk;
  task automatic tick(input int k);
    repeat (k) @(negedge refclk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic hi_len(output int c);
    c = 0;
    while (pll_rst && c < 200) begin c++; tick(1); end
  endtask
  task automatic lo_len(output int c);
    c = 0;
    while (!pll_rst && c < 200) begin c++; tick(1); end
  endtask
  task automatic wait_ready(output int c);
    c = 0;
    while (!ready && c < 200) begin tick(1); c++; end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_lock_loss"}, 32'(lock_loss_cnt), 0);
  endtask
  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    chk_reset("reset");
    rst = 1'b0;
    hi_len(n);
    chk("startup_pulse_len", n, 4);
    tick(3);
    pll_locked = 1'b1;
    wait_ready(n);
    chk("startup_ticks_to_run", n, 11);
    chk("startup_sys_rst", 32'(sys_rst), 0);
    chk("startup_pll_rst", 32'(pll_rst), 0);
    chk("startup_fault", 32'(fault), 0);
    chk("startup_lock_loss", 32'(lock_loss_cnt), 0);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("loss_still_ready", 32'(ready), 1);
    tick(1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    chk("loss_sys_rst", 32'(sys_rst), 1);
    chk("loss_ready", 32'(ready), 0);
    chk("loss_cnt1", 32'(lock_loss_cnt), 1);
    hi_len(n);
    chk("loss_pulse_len", n, 4);
    wait_ready(n);
    chk("loss_ticks_to_run", n, 9);
    pll_locked = 1'b0;
    tick(2);
    chk("glitch_pre_ready", 32'(ready), 1);
    tick(1);
    chk("glitch_pll_rst", 32'(pll_rst), 1);
    chk("glitch_cnt2", 32'(lock_loss_cnt), 2);
    tick(4);
    chk("glitch_wait_lock", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    chk("glitch_sys_rst_held", 32'(sys_rst), 1);
    chk("glitch_no_pll_rst", 32'(pll_rst), 0);
    tick(6);
    chk("glitch_restart_not_done", 32'(sys_rst), 1);
    tick(1);
    chk("glitch_run", 32'(ready), 1);
    pll_locked = 1'b0;
    tick(3);
    chk("timeout_first_pulse", 32'(pll_rst), 1);
    chk("timeout_cnt3", 32'(lock_loss_cnt), 3);
    for (int k = 0; k < 3; k++) begin
      hi_len(n);
      chk($sformatf("timeout_pulse%0d", k), n, 4);
      chk($sformatf("timeout_nofault%0d", k), 32'(fault), 0);
      lo_len(n);
      chk($sformatf("timeout_wait%0d", k), n, 20);
    end
    chk("fault_set", 32'(fault), 1);
    chk("fault_pll_rst", 32'(pll_rst), 1);
    pll_locked = 1'b1;
    tick(40);
    chk("fault_hold", 32'(fault), 1);
    chk("fault_hold_pll_rst", 32'(pll_rst), 1);
    chk("fault_hold_sys_rst", 32'(sys_rst), 1);
    chk("fault_hold_ready", 32'(ready), 0);
    rst = 1'b1;
    tick(1);
    chk_reset("rst_from_fault");
    rst = 1'b0;
    wait_ready(n);
    chk("relock_ticks_to_run", n, 13);
    for (int i = 1; i <= 256; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      wait_ready(n);
      chk($sformatf("sat_resequence%0d", i), n, 13);
      chk($sformatf("sat_cnt%0d", i), 32'(lock_loss_cnt), i > 255 ? 255 : i);
    end
    rst = 1'b1;
    tick(1);
    chk_reset("rst_mid_run");
    rst = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
